// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the in-order RV32I core: datapath width, opcode
// encodings, instruction field positions, ALU operation and writeback
// select enums, the control bundle carried down the pipe, and the
// decode/execute pipeline register layout.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned WORD = 32;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Instruction field LSB positions
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned F3_LSB  = 12;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned F7_LSB  = 25;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    // All-zero value is a NOP: ADD, no writes, no memory, no control flow.
    typedef struct packed {
        alu_op_t    aluOp;
        logic       aluSrcImm;
        logic       aluSrcPc;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic [2:0] memFunct3;
        logic       branch;
        logic [2:0] branchFunct3;
        logic       jump;
        logic       jalr;
        wb_sel_t    wbSel;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic [WORD-1:0] pc;
        logic [WORD-1:0] rs1Val;
        logic [WORD-1:0] rs2Val;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [WORD-1:0] imm;
        ctrl_t           ctrl;
    } de_reg_t;

    // Register/immediate ALU op from funct3; alt selects SUB/SRA.
    function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_floprc.sv
// -----------------------------------------------------------------------------
// floprc
// Resettable flop with synchronous clear and load enable.
// Priority: reset > clear > enable.
// Ports:
//   clk, reset   clock, synchronous reset (q <= 0)
//   i_clr        synchronous clear (q <= 0)
//   i_en         load d when high, hold otherwise
//   i_d, o_q     data in / out, W bits
// -----------------------------------------------------------------------------
module floprc #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/decode_regfile.sv
// -----------------------------------------------------------------------------
// regfile
// Integer register file: REGS x WORD, two combinational read ports, one
// write port. x0 reads zero and is never written. A read of the index being
// written this cycle returns the write data (write-through bypass).
// Synchronous active-high reset clears every register.
// Ports:
//   clk, reset           clock, synchronous reset
//   i_we, i_waddr, i_wdata  write port
//   i_raddr1, o_rdata1   read port 1
//   i_raddr2, o_rdata2   read port 2
// -----------------------------------------------------------------------------
module regfile
    import cpu_pkg::*;
#(
    parameter int unsigned REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [WORD-1:0] i_wdata,
    input  logic [4:0]      i_raddr1,
    output logic [WORD-1:0] o_rdata1,
    input  logic [4:0]      i_raddr2,
    output logic [WORD-1:0] o_rdata2
);

    logic [WORD-1:0] r_regs [REGS];
    logic            w_wrOk;

    assign w_wrOk = i_we && (i_waddr != 5'd0) && (32'(i_waddr) < REGS);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrOk) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = '0;
        if (i_raddr1 != 5'd0 && 32'(i_raddr1) < REGS) begin
            if (w_wrOk && i_waddr == i_raddr1) begin
                o_rdata1 = i_wdata;
            end else begin
                o_rdata1 = r_regs[i_raddr1];
            end
        end
    end

    always_comb begin
        o_rdata2 = '0;
        if (i_raddr2 != 5'd0 && 32'(i_raddr2) < REGS) begin
            if (w_wrOk && i_waddr == i_raddr2) begin
                o_rdata2 = i_wdata;
            end else begin
                o_rdata2 = r_regs[i_raddr2];
            end
        end
    end

endmodule

// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode
// Second pipeline stage of the RV32I core. Reads rs1/rs2 from the owned
// register file, builds the sign-extended immediate and the control bundle,
// and registers everything into the decode/execute register.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pcD, instrD                PC and instruction word from fetch
//   stallD, flushD             hold / bubble the decode/execute register
//   wbEn, wbAddr, wbData       register-file write port from writeback
//   validE, illegalE           execute holds a real / unsupported instruction
//   pcE, rs1ValE, rs2ValE      registered PC and operand values
//   rs1E, rs2E, rdE            registered register indices
//   immE, ctrlE                registered immediate and control bundle
// -----------------------------------------------------------------------------
module decode
    import cpu_pkg::*;
#(
    parameter int unsigned REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] pcD,
    input  logic [WORD-1:0] instrD,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            wbEn,
    input  logic [4:0]      wbAddr,
    input  logic [WORD-1:0] wbData,
    output logic            validE,
    output logic [WORD-1:0] pcE,
    output logic [WORD-1:0] rs1ValE,
    output logic [WORD-1:0] rs2ValE,
    output logic [4:0]      rs1E,
    output logic [4:0]      rs2E,
    output logic [4:0]      rdE,
    output logic [WORD-1:0] immE,
    output ctrl_t           ctrlE,
    output logic            illegalE
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [WORD-1:0] w_rs1Val;
    logic [WORD-1:0] w_rs2Val;
    logic [WORD-1:0] w_imm;
    ctrl_t           w_ctrl;
    logic            w_legal;
    de_reg_t         w_deNext;
    de_reg_t         w_deQ;

    assign w_opcode = instrD[6:0];
    assign w_rd     = instrD[RD_LSB  +: 5];
    assign w_f3     = instrD[F3_LSB  +: 3];
    assign w_rs1    = instrD[RS1_LSB +: 5];
    assign w_rs2    = instrD[RS2_LSB +: 5];
    assign w_f7     = instrD[F7_LSB  +: 7];

    regfile #(
        .REGS (REGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .i_we     (wbEn),
        .i_waddr  (wbAddr),
        .i_wdata  (wbData),
        .i_raddr1 (w_rs1),
        .o_rdata1 (w_rs1Val),
        .i_raddr2 (w_rs2),
        .o_rdata2 (w_rs2Val)
    );

    // Immediate generator
    always_comb begin
        w_imm = '0;
        case (w_opcode)
            OPC_JALR, OPC_LOAD, OPC_OPIMM:
                w_imm = {{20{instrD[31]}}, instrD[31:20]};
            OPC_STORE:
                w_imm = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
            OPC_BRANCH:
                w_imm = {{19{instrD[31]}}, instrD[31], instrD[7],
                         instrD[30:25], instrD[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                w_imm = {instrD[31:12], 12'b0};
            OPC_JAL:
                w_imm = {{11{instrD[31]}}, instrD[31], instrD[19:12],
                         instrD[20], instrD[30:21], 1'b0};
            default:
                w_imm = '0;
        endcase
    end

    // Control decoder
    always_comb begin
        w_ctrl  = '0;
        w_legal = 1'b1;
        case (w_opcode)
            OPC_LUI: begin
                w_ctrl.aluOp     = ALU_PASSB;
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.regWrite  = 1'b1;
            end
            OPC_AUIPC: begin
                w_ctrl.aluOp     = ALU_ADD;
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.aluSrcPc  = 1'b1;
                w_ctrl.regWrite  = 1'b1;
            end
            OPC_JAL: begin
                w_ctrl.aluOp     = ALU_ADD;
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.aluSrcPc  = 1'b1;
                w_ctrl.regWrite  = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_ctrl.wbSel     = WB_PC4;
            end
            OPC_JALR: begin
                w_legal          = (w_f3 == 3'b000);
                w_ctrl.aluOp     = ALU_ADD;
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.regWrite  = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_ctrl.jalr      = 1'b1;
                w_ctrl.wbSel     = WB_PC4;
            end
            OPC_BRANCH: begin
                w_legal             = (w_f3 != 3'b010) && (w_f3 != 3'b011);
                w_ctrl.aluOp        = ALU_SUB;
                w_ctrl.branch       = 1'b1;
                w_ctrl.branchFunct3 = w_f3;
            end
            OPC_LOAD: begin
                w_legal          = (w_f3 == 3'b000) || (w_f3 == 3'b001) ||
                                   (w_f3 == 3'b010) || (w_f3 == 3'b100) ||
                                   (w_f3 == 3'b101);
                w_ctrl.aluOp     = ALU_ADD;
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.regWrite  = 1'b1;
                w_ctrl.memRead   = 1'b1;
                w_ctrl.memFunct3 = w_f3;
                w_ctrl.wbSel     = WB_MEM;
            end
            OPC_STORE: begin
                w_legal          = (w_f3 == 3'b000) || (w_f3 == 3'b001) ||
                                   (w_f3 == 3'b010);
                w_ctrl.aluOp     = ALU_ADD;
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.memWrite  = 1'b1;
                w_ctrl.memFunct3 = w_f3;
            end
            OPC_OPIMM: begin
                // instr[30] is an immediate bit except in the shift encodings
                if (w_f3 == 3'b001) begin
                    w_legal = (w_f7 == F7_BASE);
                end else if (w_f3 == 3'b101) begin
                    w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                end
                w_ctrl.aluOp     = alu_from_funct3(w_f3, (w_f3 == 3'b101) && instrD[30]);
                w_ctrl.aluSrcImm = 1'b1;
                w_ctrl.regWrite  = 1'b1;
            end
            OPC_OP: begin
                w_legal = (w_f7 == F7_BASE) ||
                          ((w_f7 == F7_ALT) && (w_f3 == 3'b000 || w_f3 == 3'b101));
                w_ctrl.aluOp    = alu_from_funct3(w_f3, instrD[30]);
                w_ctrl.regWrite = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // An all-zero word is a bubble; illegal words travel with no side effects.
    always_comb begin
        w_deNext = '0;
        if (instrD != '0) begin
            w_deNext.valid   = 1'b1;
            w_deNext.illegal = !w_legal;
            w_deNext.pc      = pcD;
            w_deNext.rs1Val  = w_rs1Val;
            w_deNext.rs2Val  = w_rs2Val;
            w_deNext.rs1     = w_rs1;
            w_deNext.rs2     = w_rs2;
            w_deNext.rd      = w_rd;
            w_deNext.imm     = w_imm;
            w_deNext.ctrl    = w_legal ? w_ctrl : '0;
        end
    end

    floprc #(
        .W ($bits(de_reg_t))
    ) u_dereg (
        .clk   (clk),
        .reset (reset),
        .i_clr (flushD),
        .i_en  (!stallD),
        .i_d   (w_deNext),
        .o_q   (w_deQ)
    );

    assign validE   = w_deQ.valid;
    assign illegalE = w_deQ.illegal;
    assign pcE      = w_deQ.pc;
    assign rs1ValE  = w_deQ.rs1Val;
    assign rs2ValE  = w_deQ.rs2Val;
    assign rs1E     = w_deQ.rs1;
    assign rs2E     = w_deQ.rs2;
    assign rdE      = w_deQ.rd;
    assign immE     = w_deQ.imm;
    assign ctrlE    = w_deQ.ctrl;

endmodule

// File: tb/tb_decode.sv
// -----------------------------------------------------------------------------
// tb_decode
// Scoreboard bench for decode: each directed vector is driven on the falling
// edge together with its hand-computed expected *E outputs; a monitor pops
// one expectation per cycle just after the rising edge and compares.
// -----------------------------------------------------------------------------
module tb_decode;
    import cpu_pkg::*;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        ctrl_t       ctrl;
    } exp_t;

    typedef struct {
        int   id;
        exp_t e;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pcD = '0;
    logic [31:0] instrD = '0;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic        wbEn = 1'b0;
    logic [4:0]  wbAddr = '0;
    logic [31:0] wbData = '0;
    logic        validE;
    logic [31:0] pcE;
    logic [31:0] rs1ValE;
    logic [31:0] rs2ValE;
    logic [4:0]  rs1E;
    logic [4:0]  rs2E;
    logic [4:0]  rdE;
    logic [31:0] immE;
    ctrl_t       ctrlE;
    logic        illegalE;

    sb_item_t sb[$];
    int       total = 0;
    int       bad = 0;
    int       n_step = 0;

    always #5 clk = ~clk;

    decode #(
        .REGS (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pcD      (pcD),
        .instrD   (instrD),
        .stallD   (stallD),
        .flushD   (flushD),
        .wbEn     (wbEn),
        .wbAddr   (wbAddr),
        .wbData   (wbData),
        .validE   (validE),
        .pcE      (pcE),
        .rs1ValE  (rs1ValE),
        .rs2ValE  (rs2ValE),
        .rs1E     (rs1E),
        .rs2E     (rs2E),
        .rdE      (rdE),
        .immE     (immE),
        .ctrlE    (ctrlE),
        .illegalE (illegalE)
    );

    function automatic ctrl_t mk_ctrl(input alu_op_t op, input logic srcImm, input logic srcPc,
                                      input logic regW, input logic memR, input logic memW,
                                      input logic [2:0] mf3, input logic br, input logic [2:0] bf3,
                                      input logic j, input logic jr, input wb_sel_t wb);
        ctrl_t c;
        c.aluOp        = op;
        c.aluSrcImm    = srcImm;
        c.aluSrcPc     = srcPc;
        c.regWrite     = regW;
        c.memRead      = memR;
        c.memWrite     = memW;
        c.memFunct3    = mf3;
        c.branch       = br;
        c.branchFunct3 = bf3;
        c.jump         = j;
        c.jalr         = jr;
        c.wbSel        = wb;
        return c;
    endfunction

    function automatic exp_t mk_exp(input logic v, input logic ill, input logic [31:0] pc,
                                    input logic [31:0] r1v, input logic [31:0] r2v,
                                    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                    input logic [31:0] imm, input ctrl_t c);
        exp_t e;
        e.valid   = v;
        e.illegal = ill;
        e.pc      = pc;
        e.rs1v    = r1v;
        e.rs2v    = r2v;
        e.rs1     = r1;
        e.rs2     = r2;
        e.rd      = rd;
        e.imm     = imm;
        e.ctrl    = c;
        return e;
    endfunction

    task automatic step(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                        input logic st, input logic fl, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input exp_t e);
        sb_item_t it;
        @(negedge clk);
        reset  = rst;
        instrD = ins;
        pcD    = pc;
        stallD = st;
        flushD = fl;
        wbEn   = we;
        wbAddr = wa;
        wbData = wd;
        it.id  = n_step;
        it.e   = e;
        sb.push_back(it);
        n_step++;
    endtask

    // Monitor: one expectation per cycle, sampled 1ns after the rising edge
    initial begin
        sb_item_t it;
        exp_t     got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                got = mk_exp(validE, illegalE, pcE, rs1ValE, rs2ValE, rs1E, rs2E, rdE, immE, ctrlE);
                total++;
                if (got !== it.e) begin
                    bad++;
                    $display("FAIL step%0d: got v=%0b ill=%0b pc=%h r1v=%h r2v=%h rs1=%0d rs2=%0d rd=%0d imm=%h ctrl=%h ; want v=%0b ill=%0b pc=%h r1v=%h r2v=%h rs1=%0d rs2=%0d rd=%0d imm=%h ctrl=%h",
                             it.id, got.valid, got.illegal, got.pc, got.rs1v, got.rs2v, got.rs1, got.rs2,
                             got.rd, got.imm, got.ctrl, it.e.valid, it.e.illegal, it.e.pc, it.e.rs1v,
                             it.e.rs2v, it.e.rs1, it.e.rs2, it.e.rd, it.e.imm, it.e.ctrl);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t  z;
        exp_t  a2;
        ctrl_t c_addi, c_add, c_beq, c_lw, c_sw, c_lui, c_jal, c_srai;

        z      = '0;
        c_addi = mk_ctrl(ALU_ADD,   1, 0, 1, 0, 0, 3'd0, 0, 3'd0, 0, 0, WB_ALU);
        c_add  = mk_ctrl(ALU_ADD,   0, 0, 1, 0, 0, 3'd0, 0, 3'd0, 0, 0, WB_ALU);
        c_beq  = mk_ctrl(ALU_SUB,   0, 0, 0, 0, 0, 3'd0, 1, 3'd0, 0, 0, WB_ALU);
        c_lw   = mk_ctrl(ALU_ADD,   1, 0, 1, 1, 0, 3'd2, 0, 3'd0, 0, 0, WB_MEM);
        c_sw   = mk_ctrl(ALU_ADD,   1, 0, 0, 0, 1, 3'd2, 0, 3'd0, 0, 0, WB_ALU);
        c_lui  = mk_ctrl(ALU_PASSB, 1, 0, 1, 0, 0, 3'd0, 0, 3'd0, 0, 0, WB_ALU);
        c_jal  = mk_ctrl(ALU_ADD,   1, 1, 1, 0, 0, 3'd0, 0, 3'd0, 1, 0, WB_PC4);
        c_srai = mk_ctrl(ALU_SRA,   1, 0, 1, 0, 0, 3'd0, 0, 3'd0, 0, 0, WB_ALU);

        // reset
        step(1, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, z);
        step(1, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, z);
        // addi x1,x0,5
        step(0, 32'h00500093, 32'h100, 0, 0, 0, 5'd0, 32'h0,
             mk_exp(1, 0, 32'h100, 0, 0, 0, 5, 1, 32'd5, c_addi));
        // add x2,x1,x1 with x1 <= 0x1234 in the same cycle (bypass)
        step(0, 32'h00108133, 32'h104, 0, 0, 1, 5'd1, 32'h1234,
             mk_exp(1, 0, 32'h104, 32'h1234, 32'h1234, 1, 1, 2, 32'h0, c_add));
        // re-read x1 from storage
        step(0, 32'h00108133, 32'h108, 0, 0, 0, 5'd0, 32'h0,
             mk_exp(1, 0, 32'h108, 32'h1234, 32'h1234, 1, 1, 2, 32'h0, c_add));
        // beq x0,x0,-4 while writing x0 (must be ignored)
        step(0, 32'hFE000EE3, 32'h10C, 0, 0, 1, 5'd0, 32'hDEAD,
             mk_exp(1, 0, 32'h10C, 0, 0, 0, 0, 29, 32'hFFFFFFFC, c_beq));
        step(0, 32'hFE000EE3, 32'h110, 0, 0, 0, 5'd0, 32'h0,
             mk_exp(1, 0, 32'h110, 0, 0, 0, 0, 29, 32'hFFFFFFFC, c_beq));
        // illegal all-ones word, then a zero word
        step(0, 32'hFFFFFFFF, 32'h114, 0, 0, 0, 5'd0, 32'h0,
             mk_exp(1, 1, 32'h114, 0, 0, 31, 31, 31, 32'h0, '0));
        step(0, 32'h0, 32'h118, 0, 0, 0, 5'd0, 32'h0, z);
        // load addi, then stall three cycles (with an x6 write during the stall)
        a2 = mk_exp(1, 0, 32'h200, 0, 0, 0, 5, 1, 32'd5, c_addi);
        step(0, 32'h00500093, 32'h200, 0, 0, 0, 5'd0, 32'h0, a2);
        step(0, 32'h00108133, 32'h204, 1, 0, 0, 5'd0, 32'h0, a2);
        step(0, 32'hFE000EE3, 32'h208, 1, 0, 1, 5'd6, 32'h55, a2);
        step(0, 32'hFFFFFFFF, 32'h20C, 1, 0, 0, 5'd0, 32'h0, a2);
        // stall + flush together -> bubble
        step(0, 32'h00500093, 32'h210, 1, 1, 0, 5'd0, 32'h0, z);
        // add x7,x6,x1 : write made during stall is visible
        step(0, 32'h001303B3, 32'h300, 0, 0, 0, 5'd0, 32'h0,
             mk_exp(1, 0, 32'h300, 32'h55, 32'h1234, 6, 1, 7, 32'h0, c_add));
        // x5 <= 7 (addi reads x5 through rs2 field, bypassed)
        step(0, 32'h00500093, 32'h304, 0, 0, 1, 5'd5, 32'd7,
             mk_exp(1, 0, 32'h304, 0, 32'd7, 0, 5, 1, 32'd5, c_addi));
        // reset mid-stream
        step(1, 32'h001303B3, 32'h308, 0, 0, 0, 5'd0, 32'h0, z);
        // x5 cleared
        step(0, 32'h00500093, 32'h30C, 0, 0, 0, 5'd0, 32'h0,
             mk_exp(1, 0, 32'h30C, 0, 0, 0, 5, 1, 32'd5, c_addi));
        // lw x8,8(x1)
        step(0, 32'h0080A403, 32'h310, 0, 0, 0, 5'd0, 32'h0,
             mk_exp(1, 0, 32'h310, 0, 0, 1, 8, 8, 32'd8, c_lw));
        // sw x2,-4(x1)
        step(0, 32'hFE20AE23, 32'h314, 0, 0, 0, 5'd0, 32'h0,
             mk_exp(1, 0, 32'h314, 0, 0, 1, 2, 28, 32'hFFFFFFFC, c_sw));
        // lui x10,0x12345
        step(0, 32'h12345537, 32'h318, 0, 0, 0, 5'd0, 32'h0,
             mk_exp(1, 0, 32'h318, 0, 0, 8, 3, 10, 32'h12345000, c_lui));
        // jal x1,+8
        step(0, 32'h008000EF, 32'h31C, 0, 0, 0, 5'd0, 32'h0,
             mk_exp(1, 0, 32'h31C, 0, 0, 0, 8, 1, 32'd8, c_jal));
        // OP with funct7=1 (M extension) is illegal
        step(0, 32'h02000033, 32'h320, 0, 0, 0, 5'd0, 32'h0,
             mk_exp(1, 1, 32'h320, 0, 0, 0, 0, 0, 32'h0, '0));
        // srai x4,x4,1
        step(0, 32'h40125213, 32'h324, 0, 0, 0, 5'd0, 32'h0,
             mk_exp(1, 0, 32'h324, 0, 0, 4, 1, 4, 32'h401, c_srai));
        // drain with bubbles
        step(0, 32'h0, 32'h328, 0, 0, 0, 5'd0, 32'h0, z);
        step(0, 32'h0, 32'h32C, 0, 0, 0, 5'd0, 32'h0, z);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
